// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive path.
//            UART_RX_PARITY_EN adds the PARITY state to the enum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_ctrl_if
// Brief    : Receive byte handshake and error strobes of the UART receiver.
//            UART_RX_PARITY_EN adds the parity_err strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err, parity_err,
        output rx_ready
    );
`else
    modport master (
        output rx_data, rx_valid, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err,
        output rx_ready
    );
`endif

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_sync
// Brief    : Two-flop synchronizer for the serial line; resets to idle (1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_rx_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign o_rx_sync = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_ctrl
// Brief    : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a
//            valid/ready byte output and frame/overrun error strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           rx,
    output logic           busy,
    uart_rx_ctrl_if.master rx_bus
);

    localparam int                 c_TMR_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_TMR_W-1:0] c_TMR_FULL = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_HALF = c_TMR_W'(CLKS_PER_BIT / 2 - 1);

    logic                      w_rx_s;
    logic                      r_rx_prev;
    uart_rx_state_t            r_state,   w_state_nxt;
    logic [c_TMR_W-1:0]        r_tmr,     w_tmr_nxt;
    logic [2:0]                r_bit_idx, w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                      w_tmr_full;
    logic                      w_deliver;
    logic                      w_frame_bad;
    logic [UART_DATA_BITS-1:0] r_rx_data;
    logic                      r_rx_valid;
    logic                      r_frame_err;
    logic                      r_overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad, w_par_bad_nxt;
    logic                      w_par_err;
    logic                      r_parity_err;
`endif

    uart_rx_sync u_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_rx      (rx),
        .o_rx_sync (w_rx_s)
    );

    assign w_tmr_full = (r_tmr == c_TMR_FULL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_tmr     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_prev <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tmr     <= w_tmr_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_rx_prev <= w_rx_s;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = r_tmr;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_par_err     = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                w_tmr_nxt     = '0;
                w_bit_idx_nxt = '0;
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nxt = ST_START;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end
            ST_START: begin
                // Mid-start-bit check: a line already back high was a glitch.
                if (r_tmr == c_TMR_HALF) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tmr_full) begin
                    w_tmr_nxt     = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tmr_full) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_STOP;
                    if ((^r_shift) != w_rx_s) begin
                        w_par_bad_nxt = 1'b1;
                        w_par_err     = 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_tmr_full) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_deliver = !r_par_bad;
`else
                        w_deliver = 1'b1;
`endif
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_frame_err   <= w_frame_bad;
            r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= w_par_err;
`endif
            // A pending byte that is not being taken this cycle wins over the new one.
            if (w_deliver) begin
                if (r_rx_valid && !rx_bus.rx_ready) begin
                    r_overrun_err <= 1'b1;
                end else begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign busy               = (r_state != ST_IDLE);
    assign rx_bus.rx_data     = r_rx_data;
    assign rx_bus.rx_valid    = r_rx_valid;
    assign rx_bus.frame_err   = r_frame_err;
    assign rx_bus.overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err  = r_parity_err;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per serial bit; legal range is an even value >= 4.
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; all state updates on posedge clock.
REQ-003 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port rx, input, 1 bit, SHALL be the asynchronous serial line, idle high.
REQ-005 Port rx_data, output, 8 bits, SHALL carry the received byte, LSB first on the wire.
REQ-006 Port rx_valid, output, 1 bit, SHALL indicate rx_data holds an unconsumed byte.
REQ-007 Port rx_ready, input, 1 bit, SHALL indicate the consumer accepts rx_data.
REQ-008 Port frame_err, output, 1 bit, SHALL pulse for one cycle on a bad stop bit.
REQ-009 Port overrun_err, output, 1 bit, SHALL pulse for one cycle when a byte is dropped.
REQ-010 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 States SHALL be IDLE, START, DATA, (PARITY), STOP; one bit-timer counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-013 IDLE -> START on a synchronized falling edge (previous 1, current 0); bit timer cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles, rx==0 -> DATA with timer cleared; rx==1 -> IDLE with no output (glitch reject).
REQ-015 DATA: sample rx every CLKS_PER_BIT cycles into a shift register, LSB first; after bit index 7 -> STOP (or PARITY).
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> byte delivered; 0 -> frame_err pulse, byte discarded; both -> IDLE.
REQ-017 Delivery SHALL load rx_data and set rx_valid on the cycle after the stop sample.
REQ-018 rx_valid and rx_data SHALL hold stable until a cycle with rx_valid && rx_ready, after which rx_valid clears.
REQ-019 A byte completing while rx_valid is high and rx_ready is low SHALL be dropped, keep old rx_data, and pulse overrun_err.
REQ-020 A byte completing in the same cycle as a handshake SHALL load the new byte, keep rx_valid high, no overrun_err.
REQ-021 A new start edge SHALL be accepted in the cycle IDLE is re-entered; back-to-back frames are supported.

Reset
REQ-022 reset_n low SHALL force, asynchronously: state IDLE, counters 0, shift register 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun_err 0, busy 0, synchronizer flops 1.
REQ-023 Reset mid-frame SHALL discard the partial byte; no error pulses follow reset release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined SHALL add state PARITY (one bit after data, even parity) and output parity_err (1 bit, one-cycle pulse); a mismatched byte is discarded and not delivered.
REQ-025 UART_RX_PARITY_EN undefined SHALL give 8N1 framing, no PARITY state, no parity_err port.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum type, UART_DATA_BITS = 8 and the default CLKS_PER_BIT.
REQ-027 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification (CLKS_PER_BIT = 16, rx_ready high unless stated)
REQ-028 Frame 0xA5 8N1 -> rx_data=0xA5, rx_valid high 155 +/- 1 clocks after rx falls, frame_err 0.
REQ-029 rx low for 4 clocks then high -> busy returns 0 within 12 clocks, rx_valid never rises.
REQ-030 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0.
REQ-031 rx_ready low, frames 0x11 then 0x22 -> overrun_err pulse on second, rx_data stays 0x11, rx_valid stays high.
REQ-032 reset_n low at bit 4 of 0x5A, released, then frame 0x81 -> only 0x81 delivered, no error pulses.
REQ-033 UART_RX_PARITY_EN defined, 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_data=0x07.
